// File: rtl/sdp_wdma_atom_split.sv
`timescale 1ns/1ps
// Splits {mask, 4 atoms} write beats into {1'b1, atom} words, lowest atom first; NVDLA_SDP_SPLIT_ERR_EN adds a sticky illegal-mask flag.
// Latency: first atom one cycle after the beat is accepted; one atom per cycle thereafter, no bubble between beats.
// Backpressure: out_prdy low freezes the current atom; inp_prdy is high only in IDLE or when the last atom is being taken.
module sdp_wdma_atom_split #(
  parameter int ATOM_W = 64
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rst,
  input  logic                  inp_pvld,
  output logic                  inp_prdy,
  input  logic [4*ATOM_W+3:0]   inp_data,
  input  logic                  inp_end,
  output logic                  out_pvld,
  input  logic                  out_prdy,
  output logic [ATOM_W:0]       out_data,
  output logic                  out_end,
  output logic                  err
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                   state, state_nxt;
  logic [3:0][ATOM_W-1:0]   hold_data;
  logic [3:0]               hold_mask;
  logic                     hold_end;
  logic [1:0]               atom_idx;

  logic                     hold_vld;
  logic [3:0]               inp_mask;
  logic                     inp_acc;
  logic                     load;
  logic [1:0]               last_idx;
  logic                     is_last_atom;
  logic                     beat_done;

  assign hold_vld = (state == SEND);
  assign inp_mask = inp_data[4*ATOM_W +: 4];
  assign inp_acc  = inp_pvld & inp_prdy;
  assign load     = inp_acc & (|inp_mask);

  // popcount-1 in 2-bit arithmetic; wraps correctly to 3 for a full mask, and an empty mask is never held
  assign last_idx = {1'b0, hold_mask[0]} + {1'b0, hold_mask[1]}
                  + {1'b0, hold_mask[2]} + {1'b0, hold_mask[3]} - 2'd1;
  assign is_last_atom = (atom_idx == last_idx);
  assign beat_done    = hold_vld & out_prdy & is_last_atom;

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      state     <= IDLE;
      hold_mask <= 4'h0;
      hold_end  <= 1'b0;
      atom_idx  <= 2'd0;
    end else begin
      state <= state_nxt;
      if (load) begin
        hold_mask <= inp_mask;
        hold_end  <= inp_end;
        atom_idx  <= 2'd0;
      end else if (beat_done) begin
        atom_idx  <= 2'd0;
      end else if (hold_vld & out_prdy) begin
        atom_idx  <= atom_idx + 2'd1;
      end
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (load) begin
      hold_data <= inp_data[4*ATOM_W-1:0];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load) state_nxt = SEND;
      SEND:    if (beat_done) state_nxt = load ? SEND : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_pvld = hold_vld;
    out_data = {1'b1, hold_data[atom_idx]};
    out_end  = hold_vld & hold_end & is_last_atom;
    inp_prdy = !hold_vld | (out_prdy & is_last_atom);
  end

`ifdef NVDLA_SDP_SPLIT_ERR_EN
  logic err_q;
  logic mask_legal;

  assign mask_legal = (inp_mask == 4'h1) | (inp_mask == 4'h3)
                    | (inp_mask == 4'h7) | (inp_mask == 4'hf);

  always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
    if (nvdla_core_rst) begin
      err_q <= 1'b0;
    end else if (inp_acc & !mask_legal) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sdp_wdma_atom_split.sv
`timescale 1ns/1ps
// Directed bench for sdp_wdma_atom_split: hand-computed atom streams, handshakes, stalls, illegal masks and reset.
module tb_sdp_wdma_atom_split;

  localparam int ATOM_W = 64;

`ifdef NVDLA_SDP_SPLIT_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic                 nvdla_core_clk = 1'b0;
  logic                 nvdla_core_rst;
  logic                 inp_pvld;
  logic                 inp_prdy;
  logic [4*ATOM_W+3:0]  inp_data;
  logic                 inp_end;
  logic                 out_pvld;
  logic                 out_prdy;
  logic [ATOM_W:0]      out_data;
  logic                 out_end;
  logic                 err;

  int vectors     = 0;
  int miscompares = 0;

  sdp_wdma_atom_split #(.ATOM_W(ATOM_W)) dut (
    .nvdla_core_clk (nvdla_core_clk),
    .nvdla_core_rst (nvdla_core_rst),
    .inp_pvld       (inp_pvld),
    .inp_prdy       (inp_prdy),
    .inp_data       (inp_data),
    .inp_end        (inp_end),
    .out_pvld       (out_pvld),
    .out_prdy       (out_prdy),
    .out_data       (out_data),
    .out_end        (out_end),
    .err            (err)
  );

  always #5 nvdla_core_clk = ~nvdla_core_clk;

  function automatic logic [ATOM_W-1:0] atom(input int b, input int i);
    return {24'hC0FFEE, 8'(b), 24'h5A5A00, 8'(i)};
  endfunction

  function automatic logic [4*ATOM_W+3:0] beat(input logic [3:0] m, input int b);
    return {m, atom(b, 3), atom(b, 2), atom(b, 1), atom(b, 0)};
  endfunction

  task automatic chk(input string tag, input logic [ATOM_W:0] got, input logic [ATOM_W:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    chk(tag, {{ATOM_W{1'b0}}, got}, {{ATOM_W{1'b0}}, exp});
  endtask

  task automatic tick;
    @(posedge nvdla_core_clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] m, input int b, input logic e);
    inp_pvld = v;
    inp_data = beat(m, b);
    inp_end  = e;
  endtask

  task automatic idle_in;
    drive(1'b0, 4'h0, 0, 1'b0);
  endtask

  // check one cycle's outputs (v: atom expected, b/i: which atom), then advance a clock
  task automatic see(input string tag, input logic v, input int b, input int i,
                     input logic e, input logic pr);
    #1;
    chk1({tag, ".vld"}, out_pvld, v);
    if (v) chk({tag, ".dat"}, out_data, {1'b1, atom(b, i)});
    chk1({tag, ".end"}, out_end, e);
    chk1({tag, ".prdy"}, inp_prdy, pr);
    tick();
  endtask

  initial begin
    nvdla_core_rst = 1'b1;
    out_prdy       = 1'b1;
    idle_in();
    tick();
    tick();
    chk1("rst.vld", out_pvld, 1'b0);
    chk1("rst.prdy", inp_prdy, 1'b1);
    chk1("rst.end", out_end, 1'b0);
    chk1("rst.err", err, 1'b0);
    nvdla_core_rst = 1'b0;
    tick();

    // single mask-f beat with end
    drive(1'b1, 4'hf, 1, 1'b1);
    see("t1.c0", 1'b0, 0, 0, 1'b0, 1'b1);
    idle_in();
    see("t1.a0", 1'b1, 1, 0, 1'b0, 1'b0);
    see("t1.a1", 1'b1, 1, 1, 1'b0, 1'b0);
    see("t1.a2", 1'b1, 1, 2, 1'b0, 1'b0);
    see("t1.a3", 1'b1, 1, 3, 1'b1, 1'b1);
    see("t1.idle", 1'b0, 0, 0, 1'b0, 1'b1);

    // back-to-back f, 3, 1: new beats presented only on last-atom cycles
    drive(1'b1, 4'hf, 2, 1'b0);
    see("t2.c0", 1'b0, 0, 0, 1'b0, 1'b1);
    idle_in();
    see("t2.b2a0", 1'b1, 2, 0, 1'b0, 1'b0);
    see("t2.b2a1", 1'b1, 2, 1, 1'b0, 1'b0);
    see("t2.b2a2", 1'b1, 2, 2, 1'b0, 1'b0);
    drive(1'b1, 4'h3, 3, 1'b1);
    see("t2.b2a3", 1'b1, 2, 3, 1'b0, 1'b1);
    idle_in();
    see("t2.b3a0", 1'b1, 3, 0, 1'b0, 1'b0);
    drive(1'b1, 4'h1, 4, 1'b0);
    see("t2.b3a1", 1'b1, 3, 1, 1'b1, 1'b1);
    idle_in();
    see("t2.b4a0", 1'b1, 4, 0, 1'b0, 1'b1);
    see("t2.idle", 1'b0, 0, 0, 1'b0, 1'b1);

    // mask-7 beat under out_prdy pattern 1,0,0,1,1
    drive(1'b1, 4'h7, 5, 1'b1);
    see("t3.c0", 1'b0, 0, 0, 1'b0, 1'b1);
    idle_in();
    out_prdy = 1'b1;
    see("t3.a0", 1'b1, 5, 0, 1'b0, 1'b0);
    out_prdy = 1'b0;
    see("t3.a1s0", 1'b1, 5, 1, 1'b0, 1'b0);
    see("t3.a1s1", 1'b1, 5, 1, 1'b0, 1'b0);
    out_prdy = 1'b1;
    see("t3.a1", 1'b1, 5, 1, 1'b0, 1'b0);
    see("t3.a2", 1'b1, 5, 2, 1'b1, 1'b1);
    see("t3.idle", 1'b0, 0, 0, 1'b0, 1'b1);

    // mask-0 beat with end: swallowed, no atom, end lost
    drive(1'b1, 4'h0, 6, 1'b1);
    #1;
    chk1("t4.err_pre", err, 1'b0);
    see("t4.c0", 1'b0, 0, 0, 1'b0, 1'b1);
    idle_in();
    chk1("t4.err", err, ERR_EN);
    see("t4.c1", 1'b0, 0, 0, 1'b0, 1'b1);
    chk1("t4.err_hold", err, ERR_EN);

    nvdla_core_rst = 1'b1;
    #2;
    chk1("t4.err_rst", err, 1'b0);
    tick();
    nvdla_core_rst = 1'b0;
    tick();

    // non-contiguous mask 5: atoms 0 and 1 are sent
    drive(1'b1, 4'h5, 7, 1'b1);
    see("t5.c0", 1'b0, 0, 0, 1'b0, 1'b1);
    idle_in();
    chk1("t5.err_a0", err, ERR_EN);
    see("t5.a0", 1'b1, 7, 0, 1'b0, 1'b0);
    see("t5.a1", 1'b1, 7, 1, 1'b1, 1'b1);
    see("t5.idle", 1'b0, 0, 0, 1'b0, 1'b1);
    chk1("t5.err_hold", err, ERR_EN);

    // asynchronous reset while atom 2 of a mask-f beat is showing
    drive(1'b1, 4'hf, 8, 1'b1);
    see("t6.c0", 1'b0, 0, 0, 1'b0, 1'b1);
    idle_in();
    see("t6.a0", 1'b1, 8, 0, 1'b0, 1'b0);
    see("t6.a1", 1'b1, 8, 1, 1'b0, 1'b0);
    #1;
    chk("t6.a2.dat", out_data, {1'b1, atom(8, 2)});
    #1;
    nvdla_core_rst = 1'b1;
    #1;
    chk1("t6.rst.vld", out_pvld, 1'b0);
    chk1("t6.rst.prdy", inp_prdy, 1'b1);
    chk1("t6.rst.end", out_end, 1'b0);
    chk1("t6.rst.err", err, 1'b0);
    tick();
    nvdla_core_rst = 1'b0;
    tick();
    see("t6.post_idle", 1'b0, 0, 0, 1'b0, 1'b1);
    drive(1'b1, 4'h1, 9, 1'b1);
    see("t6.c0b", 1'b0, 0, 0, 1'b0, 1'b1);
    idle_in();
    see("t6.b9a0", 1'b1, 9, 0, 1'b1, 1'b1);
    see("t6.idle", 1'b0, 0, 0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sdp_wdma_atom_split.md
# sdp_wdma_atom_split

Splits 256-bit SDP write-path beats, each carrying a 4-bit atom mask, into a stream of 64-bit atoms for the write DMA. It is the inverse of the SDP read-side atom packer: it consumes `{mask[3:0], data[255:0]}` beats and emits one 65-bit atom word per valid atom, lowest atom first. The block sits between the SDP output pipeline and the WDMA request formatter. A single holding register preserves full throughput.

## Interface
- `ATOM_W`, default 64: atom width in bits. The beat holds 4 atoms, so beat data is 4*ATOM_W bits.
- `nvdla_core_clk`  in  1  core clock; all state changes on its rising edge.
- `nvdla_core_rst`  in  1  reset, asynchronous, active-high.
- `inp_pvld`  in  1  input beat valid.
- `inp_prdy`  out  1  input beat ready.
- `inp_data`  in  4*ATOM_W+4  `{mask[3:0], atom3, atom2, atom1, atom0}`.
- `inp_end`  in  1  beat is the last beat of the current surface/line.
- `out_pvld`  out  1  atom valid.
- `out_prdy`  in  1  atom ready.
- `out_data`  out  ATOM_W+1  `{1'b1, atom}`; bit ATOM_W is always 1 when `out_pvld` is high (per-atom valid bit).
- `out_end`  out  1  high on the last atom of a beat that had `inp_end` set.
- `err`  out  1  sticky illegal-mask flag (see Configuration).

## Operation
- Holding register state:
  - `hold_vld`
  - `hold_data` (4 atoms)
  - `hold_mask`
  - `hold_end`
  - `atom_idx[1:0]` (next atom to send)
- Legal masks are 4'h1, 4'h3, 4'h7 and 4'hf (contiguous from atom0). The atom count is N = popcount(mask).
- States:
  - IDLE (`hold_vld`=0): waiting for a beat.
  - SEND (`hold_vld`=1): emitting atom `atom_idx`.
- Accepted beat with a nonzero mask: load the holding register, set `atom_idx`=0, go to SEND.
- Accepted beat with mask 4'h0: dropped and never loaded. Any `inp_end` on it is lost.
- In SEND:
  - `out_data` = `{1'b1, hold_data[atom_idx]}`.
  - `is_last_atom` = (`atom_idx` == N-1).
  - On `out_pvld & out_prdy`: if not `is_last_atom`, increment `atom_idx`; otherwise the beat is done.
- `out_end` = `hold_vld & hold_end & is_last_atom`.
- Beat done with a new beat accepted in the same cycle: the new beat loads immediately, `atom_idx`=0, state stays SEND.
- Beat done with no new beat: go to IDLE.
- With a non-contiguous mask (e.g. 4'h5), N atoms are still sent from atom0 upward, i.e. atoms 0 and 1 for 4'h5. This behaviour is defined but is a protocol error.

## Timing
- `inp_prdy` = `!hold_vld | (out_prdy & is_last_atom)`. This is combinational from `out_prdy`; there is no bubble between beats.
- Latency: the first atom appears the cycle after the beat is accepted.
- Throughput: 1 atom/cycle. A mask-f beat occupies 4 cycles and a mask-1 beat occupies 1 cycle.
- `out_pvld` = `hold_vld`.
- While `out_pvld`=1 and `out_prdy`=0: `out_data` and `out_end` must stay stable, and `atom_idx` must not advance.
- Reset values:
  - `hold_vld`=0 and `atom_idx`=0, so `out_pvld`=0 and `inp_prdy`=1.
  - `out_end`=0 and `err`=0.
  - `hold_data` is not reset; `out_data` is don't-care while `out_pvld`=0.
- Reset asserted mid-beat: the in-flight beat is discarded. After reset deasserts, the block is in IDLE.

## Configuration
- `NVDLA_SDP_SPLIT_ERR_EN`:
  - Defined: `err` is set on the cycle after any accepted beat whose mask is not 1/3/7/f, including 0. `err` stays set until reset. Data behaviour is unchanged.
  - Undefined: `err` is tied to 0 and no check logic is present.

## Test plan
- Single beat, mask f, atoms A0..A3, `inp_end`=1, `out_prdy`=1 -> 4 consecutive atoms `{1,A0}`..`{1,A3}` starting the cycle after accept; `out_end`=1 only with A3.
- Back-to-back beats with masks f, 3, 1 and `out_prdy`=1 -> 7 atoms on consecutive cycles with no gaps; `inp_prdy` is high only in the cycles where the last atom of each beat is sent, or in IDLE.
- Mask 7 beat, `out_prdy` toggling 1,0,0,1,1 -> atoms A0, A1, A2 in order; each atom is held stable across stall cycles; `inp_prdy` stays 0 until A2 is accepted.
- Mask 0 beat with `inp_end`=1 -> accepted the same cycle, no output atom. With `NVDLA_SDP_SPLIT_ERR_EN` defined, `err`=1 the next cycle; without it, `err` stays 0.
- Mask 5 beat -> 2 atoms (A0, A1). With the macro defined, `err` rises and stays set until reset.
- Reset asserted during atom 2 of a mask-f beat -> `out_pvld`=0 immediately (asynchronous reset). After reset release, a new mask-1 beat produces a single atom with `out_end` matching its `inp_end`.
